// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-CPU control unit: opcodes, ALU codes, FSM states,
// the control strobe bundle and opcode classification helpers.
package cpu_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALUW-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALUW-1:0] ALU_AND  = 5'd2;
  localparam logic [ALUW-1:0] ALU_OR   = 5'd3;
  localparam logic [ALUW-1:0] ALU_SHR  = 5'd4;
  localparam logic [ALUW-1:0] ALU_SHRA = 5'd5;
  localparam logic [ALUW-1:0] ALU_SHL  = 5'd6;
  localparam logic [ALUW-1:0] ALU_ROR  = 5'd7;
  localparam logic [ALUW-1:0] ALU_ROL  = 5'd8;
  localparam logic [ALUW-1:0] ALU_MUL  = 5'd9;
  localparam logic [ALUW-1:0] ALU_DIV  = 5'd10;
  localparam logic [ALUW-1:0] ALU_NEG  = 5'd11;
  localparam logic [ALUW-1:0] ALU_NOT  = 5'd12;

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_RALU = 4'd0, C_IALU = 4'd1, C_LD = 4'd2, C_LDI = 4'd3, C_ST = 4'd4,
    C_MULDIV = 4'd5, C_NEGNOT = 4'd6, C_BR = 4'd7, C_JR = 4'd8, C_IN = 4'd9,
    C_OUT = 4'd10, C_MFHI = 4'd11, C_MFLO = 4'd12, C_NOP = 4'd13, C_HALT = 4'd14
  } op_class_t;

  typedef struct packed {
    logic            pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, inport_out, c_out;
    logic            gra, grb, grc, r_in, r_out, ba_out;
    logic            pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in, outport_in, con_in;
    logic            inc_pc, read, write, run;
    logic [ALUW-1:0] alu_select;
  } strobes_t;

  // Unlisted opcodes (jal, 11100-11111) fall into the nop class.
  function automatic op_class_t op_class(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return C_RALU;
      OP_ADDI, OP_ANDI, OP_ORI: return C_IALU;
      OP_LD:   return C_LD;
      OP_LDI:  return C_LDI;
      OP_ST:   return C_ST;
      OP_MUL, OP_DIV: return C_MULDIV;
      OP_NEG, OP_NOT: return C_NEGNOT;
      OP_BR:   return C_BR;
      OP_JR:   return C_JR;
      OP_IN:   return C_IN;
      OP_OUT:  return C_OUT;
      OP_MFHI: return C_MFHI;
      OP_MFLO: return C_MFLO;
      OP_HALT: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction

  function automatic logic [ALUW-1:0] alu_code(input logic [OPW-1:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHRA:         return ALU_SHRA;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

  function automatic state_t last_step(input op_class_t c);
    case (c)
      C_RALU, C_IALU, C_LDI: return S_T5;
      C_LD, C_ST:            return S_T7;
      C_MULDIV, C_BR:        return S_T6;
      C_NEGNOT:              return S_T4;
      default:               return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_output_decode.sv
// Moore output decode: maps the sequencer state plus the IR opcode (and the
// branch condition in br T6) onto the full datapath strobe bundle.
module cu_output_decode
  import cpu_pkg::*;
(
  input  state_t           state,
  input  logic [OPW-1:0]   ir_op,
  input  logic             con_ff,
  output strobes_t         strobes
);

  op_class_t cls_s;
  strobes_t  strobes_s;

  assign cls_s   = op_class(ir_op);
  assign strobes = strobes_s;

  // Strobe decode per fetch/execute step; everything not named stays 0.
  always_comb begin
    strobes_s = '0;
    case (state)
      S_T0: begin
        strobes_s.pc_out = 1'b1; strobes_s.mar_in = 1'b1; strobes_s.inc_pc = 1'b1; strobes_s.z_in = 1'b1;
      end
      S_T1: begin
        strobes_s.zlow_out = 1'b1; strobes_s.pc_in = 1'b1; strobes_s.read = 1'b1; strobes_s.mdr_in = 1'b1;
      end
      S_T2: begin
        strobes_s.mdr_out = 1'b1; strobes_s.ir_in = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (cls_s)
          C_RALU, C_IALU: begin
            case (state)
              S_T3: begin strobes_s.grb = 1'b1; strobes_s.r_out = 1'b1; strobes_s.y_in = 1'b1; end
              S_T4: begin
                if (cls_s == C_RALU) begin
                  strobes_s.grc = 1'b1; strobes_s.r_out = 1'b1;
                end else begin
                  strobes_s.c_out = 1'b1;
                end
                strobes_s.alu_select = alu_code(ir_op); strobes_s.z_in = 1'b1;
              end
              S_T5: begin strobes_s.zlow_out = 1'b1; strobes_s.gra = 1'b1; strobes_s.r_in = 1'b1; end
              default: begin end
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (state)
              S_T3: begin strobes_s.grb = 1'b1; strobes_s.ba_out = 1'b1; strobes_s.y_in = 1'b1; end
              S_T4: begin strobes_s.c_out = 1'b1; strobes_s.z_in = 1'b1; end
              S_T5: begin
                strobes_s.zlow_out = 1'b1;
                if (cls_s == C_LDI) begin
                  strobes_s.gra = 1'b1; strobes_s.r_in = 1'b1;
                end else begin
                  strobes_s.mar_in = 1'b1;
                end
              end
              S_T6: begin
                strobes_s.mdr_in = 1'b1;
                if (cls_s == C_ST) begin
                  strobes_s.gra = 1'b1; strobes_s.r_out = 1'b1;
                end else begin
                  strobes_s.read = 1'b1;
                end
              end
              S_T7: begin
                if (cls_s == C_ST) begin
                  strobes_s.write = 1'b1;
                end else begin
                  strobes_s.mdr_out = 1'b1; strobes_s.gra = 1'b1; strobes_s.r_in = 1'b1;
                end
              end
              default: begin end
            endcase
          end
          C_MULDIV: begin
            case (state)
              S_T3: begin strobes_s.gra = 1'b1; strobes_s.r_out = 1'b1; strobes_s.y_in = 1'b1; end
              S_T4: begin
                strobes_s.grb = 1'b1; strobes_s.r_out = 1'b1;
                strobes_s.alu_select = alu_code(ir_op); strobes_s.z_in = 1'b1;
              end
              S_T5: begin strobes_s.zlow_out = 1'b1; strobes_s.lo_in = 1'b1; end
              S_T6: begin strobes_s.zhigh_out = 1'b1; strobes_s.hi_in = 1'b1; end
              default: begin end
            endcase
          end
          C_NEGNOT: begin
            case (state)
              S_T3: begin
                strobes_s.grb = 1'b1; strobes_s.r_out = 1'b1;
                strobes_s.alu_select = alu_code(ir_op); strobes_s.z_in = 1'b1;
              end
              S_T4: begin strobes_s.zlow_out = 1'b1; strobes_s.gra = 1'b1; strobes_s.r_in = 1'b1; end
              default: begin end
            endcase
          end
          C_BR: begin
            case (state)
              S_T3: begin strobes_s.gra = 1'b1; strobes_s.r_out = 1'b1; strobes_s.con_in = 1'b1; end
              S_T4: begin strobes_s.pc_out = 1'b1; strobes_s.y_in = 1'b1; end
              S_T5: begin strobes_s.c_out = 1'b1; strobes_s.z_in = 1'b1; end
              S_T6: begin
                strobes_s.zlow_out = con_ff; strobes_s.pc_in = con_ff;
              end
              default: begin end
            endcase
          end
          C_JR:   if (state == S_T3) begin strobes_s.gra = 1'b1; strobes_s.r_out = 1'b1; strobes_s.pc_in = 1'b1; end else begin end
          C_IN:   if (state == S_T3) begin strobes_s.inport_out = 1'b1; strobes_s.gra = 1'b1; strobes_s.r_in = 1'b1; end else begin end
          C_OUT:  if (state == S_T3) begin strobes_s.gra = 1'b1; strobes_s.r_out = 1'b1; strobes_s.outport_in = 1'b1; end else begin end
          C_MFHI: if (state == S_T3) begin strobes_s.hi_out = 1'b1; strobes_s.gra = 1'b1; strobes_s.r_in = 1'b1; end else begin end
          C_MFLO: if (state == S_T3) begin strobes_s.lo_out = 1'b1; strobes_s.gra = 1'b1; strobes_s.r_in = 1'b1; end else begin end
          default: begin end
        endcase
      end
      default: begin end
    endcase
    strobes_s.run = (state inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7});
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: state register and next-state logic.
// Optional memory wait handshake (mem_ready) enabled by defining CU_MEM_WAIT_EN.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [OPW-1:0]  IR_op,
  input  logic            con_ff,
  input  logic            stop,
`ifdef CU_MEM_WAIT_EN
  input  logic            mem_ready,
`endif
  output logic            PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout,
  output logic            Gra, Grb, Grc, Rin, Rout, BAout,
  output logic            PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in, OutPort_in, CON_in,
  output logic            IncPC, Read, Write,
  output logic [ALUW-1:0] ALU_select,
  output logic            run
);

  state_t    state_r, base_s, next_s;
  op_class_t cls_s;
  logic      mem_ok_s, mem_hold_s;
  strobes_t  strobes_s;

  assign cls_s = op_class(IR_op);

`ifdef CU_MEM_WAIT_EN
  assign mem_ok_s = mem_ready;
`else
  assign mem_ok_s = 1'b1;
`endif

  assign mem_hold_s = !mem_ok_s && (((state_r == S_T6) && (cls_s == C_LD)) ||
                                    ((state_r == S_T7) && (cls_s == C_ST)));

  // Step sequencing; the halt request diverts any entry into T0.
  always_comb begin
    base_s = state_r;
    case (state_r)
      S_RST: base_s = S_T0;
      S_T0:  base_s = S_T1;
      S_T1:  base_s = mem_ok_s ? S_T2 : S_T1;
      S_T2:  base_s = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (cls_s == C_HALT) begin
          base_s = S_HALT;
        end else if (mem_hold_s) begin
          base_s = state_r;
        end else if (state_r == last_step(cls_s)) begin
          base_s = S_T0;
        end else begin
          base_s = state_t'(state_r + 4'd1);
        end
      end
      S_HALT: base_s = S_HALT;
      default: base_s = S_RST;
    endcase
    next_s = ((base_s == S_T0) && stop) ? S_HALT : base_s;
  end

  // State register; clr drops straight into the all-quiet reset state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= S_RST;
    end else begin
      state_r <= next_s;
    end
  end

  cu_output_decode u_decode (
    .state   (state_r),
    .ir_op   (IR_op),
    .con_ff  (con_ff),
    .strobes (strobes_s)
  );

  assign PCout      = strobes_s.pc_out;
  assign MDRout     = strobes_s.mdr_out;
  assign Zhighout   = strobes_s.zhigh_out;
  assign Zlowout    = strobes_s.zlow_out;
  assign HIout      = strobes_s.hi_out;
  assign LOout      = strobes_s.lo_out;
  assign InPortout  = strobes_s.inport_out;
  assign Cout       = strobes_s.c_out;
  assign Gra        = strobes_s.gra;
  assign Grb        = strobes_s.grb;
  assign Grc        = strobes_s.grc;
  assign Rin        = strobes_s.r_in;
  assign Rout       = strobes_s.r_out;
  assign BAout      = strobes_s.ba_out;
  assign PC_in      = strobes_s.pc_in;
  assign IR_in      = strobes_s.ir_in;
  assign Y_in       = strobes_s.y_in;
  assign Z_in       = strobes_s.z_in;
  assign MAR_in     = strobes_s.mar_in;
  assign MDR_in     = strobes_s.mdr_in;
  assign HI_in      = strobes_s.hi_in;
  assign LO_in      = strobes_s.lo_in;
  assign OutPort_in = strobes_s.outport_in;
  assign CON_in     = strobes_s.con_in;
  assign IncPC      = strobes_s.inc_pc;
  assign Read       = strobes_s.read;
  assign Write      = strobes_s.write;
  assign ALU_select = strobes_s.alu_select;
  assign run        = strobes_s.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction expected strobe
// sequences are queued by a table model and compared every negedge.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr, con_ff, stop;
  logic [4:0] IR_op;
`ifdef CU_MEM_WAIT_EN
  logic mem_ready;
`endif
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in, OutPort_in, CON_in;
  logic IncPC, Read, Write, run;
  logic [4:0] ALU_select;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR_op(IR_op), .con_ff(con_ff), .stop(stop),
`ifdef CU_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .MAR_in(MAR_in),
    .MDR_in(MDR_in), .HI_in(HI_in), .LO_in(LO_in), .OutPort_in(OutPort_in),
    .CON_in(CON_in), .IncPC(IncPC), .Read(Read), .Write(Write),
    .ALU_select(ALU_select), .run(run)
  );

  logic [32:0] dut_vec;
  assign dut_vec = {ALU_select, run, Write, Read, IncPC, CON_in, OutPort_in, LO_in, HI_in,
                    MDR_in, MAR_in, Z_in, Y_in, IR_in, PC_in, BAout, Rout, Rin, Grc, Grb,
                    Gra, Cout, InPortout, LOout, HIout, Zlowout, Zhighout, MDRout, PCout};

  localparam logic [32:0] M_PCOUT = 33'd1 << 0,  M_MDROUT = 33'd1 << 1,  M_ZHIGH = 33'd1 << 2;
  localparam logic [32:0] M_ZLOW  = 33'd1 << 3,  M_HIOUT  = 33'd1 << 4,  M_LOOUT = 33'd1 << 5;
  localparam logic [32:0] M_INP   = 33'd1 << 6,  M_COUT   = 33'd1 << 7,  M_GRA   = 33'd1 << 8;
  localparam logic [32:0] M_GRB   = 33'd1 << 9,  M_GRC    = 33'd1 << 10, M_RIN   = 33'd1 << 11;
  localparam logic [32:0] M_ROUT  = 33'd1 << 12, M_BAOUT  = 33'd1 << 13, M_PCIN  = 33'd1 << 14;
  localparam logic [32:0] M_IRIN  = 33'd1 << 15, M_YIN    = 33'd1 << 16, M_ZIN   = 33'd1 << 17;
  localparam logic [32:0] M_MARIN = 33'd1 << 18, M_MDRIN  = 33'd1 << 19, M_HIIN  = 33'd1 << 20;
  localparam logic [32:0] M_LOIN  = 33'd1 << 21, M_OUTIN  = 33'd1 << 22, M_CONIN = 33'd1 << 23;
  localparam logic [32:0] M_INCPC = 33'd1 << 24, M_READ   = 33'd1 << 25, M_WRITE = 33'd1 << 26;
  localparam logic [32:0] M_RUN   = 33'd1 << 27;

  int n_checks = 0;
  int n_errors = 0;
  string cur_name = "idle";
  logic [32:0] seq_q[$];
  logic [32:0] exp_q[$];

  // ALU operation each opcode must present while Z_in is high.
  function automatic logic [32:0] alu_f(input int op);
    int code;
    case (op)
      4: code = 1;  5: code = 2;  6: code = 3;  7: code = 4;  8: code = 5;
      9: code = 6;  10: code = 7; 11: code = 8; 13: code = 2; 14: code = 3;
      15: code = 9; 16: code = 10; 17: code = 11; 18: code = 12;
      default: code = 0;
    endcase
    return 33'(code) << 28;
  endfunction

  // Full per-cycle strobe sequence of one instruction, T0 to its last step.
  function automatic int build_seq(input int op, input bit con, input int t1_wait);
    logic [32:0] ex[$];
    logic [32:0] a;
    a = alu_f(op);
    if (op <= 2) begin
      ex = '{M_GRB | M_BAOUT | M_YIN, M_COUT | M_ZIN};
      if (op == 1) ex.push_back(M_ZLOW | M_GRA | M_RIN);
      else begin
        ex.push_back(M_ZLOW | M_MARIN);
        if (op == 0) begin ex.push_back(M_READ | M_MDRIN); ex.push_back(M_MDROUT | M_GRA | M_RIN); end
        else begin ex.push_back(M_GRA | M_ROUT | M_MDRIN); ex.push_back(M_WRITE); end
      end
    end
    else if (op <= 11) ex = '{M_GRB | M_ROUT | M_YIN, M_GRC | M_ROUT | M_ZIN | a, M_ZLOW | M_GRA | M_RIN};
    else if (op <= 14) ex = '{M_GRB | M_ROUT | M_YIN, M_COUT | M_ZIN | a, M_ZLOW | M_GRA | M_RIN};
    else if (op <= 16) ex = '{M_GRA | M_ROUT | M_YIN, M_GRB | M_ROUT | M_ZIN | a, M_ZLOW | M_LOIN, M_ZHIGH | M_HIIN};
    else if (op <= 18) ex = '{M_GRB | M_ROUT | M_ZIN | a, M_ZLOW | M_GRA | M_RIN};
    else if (op == 19) ex = '{M_GRA | M_ROUT | M_CONIN, M_PCOUT | M_YIN, M_COUT | M_ZIN,
                              con ? (M_ZLOW | M_PCIN) : 33'd0};
    else if (op == 20) ex = '{M_GRA | M_ROUT | M_PCIN};
    else if (op == 22) ex = '{M_INP | M_GRA | M_RIN};
    else if (op == 23) ex = '{M_GRA | M_ROUT | M_OUTIN};
    else if (op == 24) ex = '{M_HIOUT | M_GRA | M_RIN};
    else if (op == 25) ex = '{M_LOOUT | M_GRA | M_RIN};
    else ex = '{33'd0};
    seq_q.delete();
    seq_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
    for (int i = 0; i <= t1_wait; i++) seq_q.push_back(M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN);
    seq_q.push_back(M_MDROUT | M_IRIN | M_RUN);
    foreach (ex[i]) seq_q.push_back(ex[i] | M_RUN);
    return seq_q.size();
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Compare process: one expected vector consumed per clock, sampled at negedge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) check(cur_name, dut_vec, exp_q.pop_front());
  end

  task automatic drain(input string name);
    cur_name = name;
    for (int c = 0; c < 64 && exp_q.size() != 0; c++) begin
      @(negedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: %0d steps left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_instr(input int op, input bit con, input int tail);
    IR_op = 5'(op); con_ff = con;
    void'(build_seq(op, con, 0));
    exp_q = seq_q;
    for (int i = 0; i < tail; i++) exp_q.push_back(33'd0);
    drain($sformatf("op%0d_c%0d", op, con));
    @(posedge clk); #1;
  endtask

  task automatic recover();
    @(negedge clk); clr = 1'b0; stop = 1'b0; #1;
    check("clr_held", dut_vec, 33'd0);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    clr = 1'b0; con_ff = 1'b0; stop = 1'b0; IR_op = 5'd0;
`ifdef CU_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    // Model pins against hand-derived latencies and vectors.
    check("pin_len_add",  33'(build_seq(3, 0, 0)), 33'd6);
    check("pin_add_t4",   seq_q[4], 33'h0_0802_1400);
    check("pin_len_ld",   33'(build_seq(0, 0, 0)), 33'd8);
    check("pin_ld_t7",    seq_q[7], 33'h0_0800_0902);
    check("pin_len_ldi",  33'(build_seq(1, 0, 0)), 33'd6);
    check("pin_len_st",   33'(build_seq(2, 0, 0)), 33'd8);
    check("pin_len_mul",  33'(build_seq(15, 0, 0)), 33'd7);
    check("pin_len_br",   33'(build_seq(19, 1, 0)), 33'd7);
    check("pin_br_t6",    seq_q[6], 33'h0_0800_4008);
    check("pin_len_nop",  33'(build_seq(26, 0, 0)), 33'd4);
    check("pin_sub_t4",   (build_seq(4, 0, 0) == 6) ? seq_q[4] : 33'd0, 33'h0_1802_1400);

    #12;
    check("reset_state", dut_vec, 33'd0);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;

    for (int op = 0; op < 32; op++) begin
      if (op != 27) run_instr(op, 1'b0, 0);
      if (op == 19) run_instr(op, 1'b1, 0);
    end

    // clr during T4 of add: outputs drop at once, then a clean T0.
    IR_op = 5'd3; con_ff = 1'b0;
    void'(build_seq(3, 0, 0));
    exp_q = seq_q[0:4];
    drain("add_to_t4");
    clr = 1'b0; #1;
    check("clr_async", dut_vec, 33'd0);
    @(negedge clk); #1;
    check("clr_hold", dut_vec, 33'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    run_instr(3, 1'b0, 0);

    // stop raised in T2 of add: add finishes, then HALT.
    IR_op = 5'd3;
    void'(build_seq(3, 0, 0));
    exp_q = seq_q;
    for (int i = 0; i < 20; i++) exp_q.push_back(33'd0);
    cur_name = "stop_add";
    @(posedge clk); @(posedge clk); #1;
    stop = 1'b1;
    drain("stop_add");
    recover();

    run_instr(27, 1'b0, 20);
    recover();

`ifdef CU_MEM_WAIT_EN
    IR_op = 5'd0;
    void'(build_seq(0, 0, 3));
    exp_q = seq_q;
    cur_name = "ld_wait";
    mem_ready = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b1;
    drain("ld_wait");
    @(posedge clk); #1;
`endif

    run_instr(26, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
